// File: rtl/versatile_fifo_sync_dw.sv
// rtl/versatile_fifo_sync_dw.sv - single-clock FIFO on inferred dual-port RAM
//
// Purpose: same-clock buffering with fill level, threshold flags, sticky
// overflow/underflow errors and a synchronous flush.
// Optional build macro: VERSATILE_FIFO_FWFT_EN selects first-word-fall-through
// mode (output stage holds the head word); undefined gives standard mode with
// a 1-cycle registered read.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   clear         synchronous flush (pointers, level, q/q_valid); keeps errors
//   wr_en, d      write request and data
//   rd_en         read request (standard) / head acknowledge (FWFT)
//   q, q_valid    read data and its valid indication
//   full, empty, almost_full, almost_empty   decoded from level/head state
//   level         words held, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module versatile_fifo_sync_dw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = LW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_L    = LW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  pop;     // RAM word moves into q this cycle

  assign full         = (level == DEPTH_L);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);
  assign wr_acc       = wr_en & ~full;

`ifdef VERSATILE_FIFO_FWFT_EN
  // Output stage: q is the head word whenever out_valid is set. level counts
  // it too, so "empty" means no head is displayed, not level == 0 (a word
  // just written sits in RAM for one cycle before it is prefetched).
  logic out_valid;

  assign empty   = ~out_valid;
  assign q_valid = out_valid;
  assign rd_acc  = rd_en & out_valid;
  // Refill the output stage when it is vacant or being consumed. RAM is
  // non-empty exactly when the pointers differ, so a prefetch never reads
  // the address being written in the same cycle.
  assign pop     = (wr_ptr != rd_ptr) & (~out_valid | rd_acc);
`else
  logic q_valid_r;

  assign empty   = (level == '0);
  assign q_valid = q_valid_r;
  assign rd_acc  = rd_en & ~empty;
  assign pop     = rd_acc;
`endif

  // RAM array has no reset; writes are suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst && !clear) begin
      ram[wr_ptr[ADDR_WIDTH-1:0]] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      q      <= '0;
`ifdef VERSATILE_FIFO_FWFT_EN
      out_valid <= 1'b0;
`else
      q_valid_r <= 1'b0;
`endif
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        q      <= ram[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        level <= level + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        level <= level - 1'b1;
      end
`ifdef VERSATILE_FIFO_FWFT_EN
      out_valid <= pop | (out_valid & ~rd_acc);
`else
      q_valid_r <= rd_acc;
`endif
    end
  end

  // Error flags survive a flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!clear) begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
